// File: rtl/glyph_banner_ctrl.sv
// Banner sequencer: reveals glyphs one at a time, slides the row to its resting
// line, blinks it, then holds until acknowledged. Advances only on frame ticks.
module glyph_banner_ctrl #(
   parameter int unsigned NCHARS        = 8,
   parameter int unsigned REVEAL_FRAMES = 4,
   parameter logic [9:0]  START_Y       = 10'd0,
   parameter logic [9:0]  TARGET_Y      = 10'd220,
   parameter int unsigned SLIDE_STEP    = 8,
   parameter int unsigned BLINK_FRAMES  = 15,
   parameter int unsigned BLINK_COUNT   = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              frame_tick,
   input  logic              trigger,
   input  logic              ack,
   output logic [9:0]        banner_y,
   output logic [NCHARS-1:0] char_en,
   output logic              visible,
   output logic              busy
);

   localparam logic [7:0]        REVEAL_LAST = 8'(REVEAL_FRAMES);
   localparam logic [7:0]        BLINK_LAST  = 8'(BLINK_FRAMES);
   localparam logic [4:0]        TOGGLE_LAST = 5'(2 * BLINK_COUNT);
   localparam logic [10:0]       STEP_W      = 11'(SLIDE_STEP);
   localparam logic [10:0]       TARGET_W    = {1'b0, TARGET_Y};
   localparam logic [NCHARS-1:0] CHAR_ONE    = NCHARS'(1'b1);
   localparam logic [NCHARS-1:0] CHAR_ALL    = {NCHARS{1'b1}};

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      REVEAL = 3'd1,
      SLIDE  = 3'd2,
      BLINK  = 3'd3,
      HOLD   = 3'd4
   } state_t;

   state_t            state_r;
   logic [7:0]        frame_cnt_r;
   logic [4:0]        toggle_cnt_r;
   logic [7:0]        frame_inc_s;
   logic [4:0]        toggle_inc_s;
   logic [NCHARS-1:0] char_next_s;
   logic [10:0]       y_sum_s;
   logic [9:0]        y_next_s;

   // Next-value helpers: counter increments, lowest-clear-bit reveal, saturating slide
   always_comb begin
      frame_inc_s  = frame_cnt_r + 8'd1;
      toggle_inc_s = toggle_cnt_r + 5'd1;
      char_next_s  = char_en | (char_en + CHAR_ONE);
      y_sum_s      = {1'b0, banner_y} + STEP_W;
      if (y_sum_s >= TARGET_W) begin
         y_next_s = TARGET_Y;
      end else begin
         y_next_s = y_sum_s[9:0];
      end
   end

   // Sequencer state, counters and registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r      <= IDLE;
         frame_cnt_r  <= 8'd0;
         toggle_cnt_r <= 5'd0;
         banner_y     <= START_Y;
         char_en      <= '0;
         visible      <= 1'b0;
         busy         <= 1'b0;
      end else if ((state_r != IDLE) && ack) begin
         // Abort/dismiss wins over any tick in the same cycle
         state_r      <= IDLE;
         frame_cnt_r  <= 8'd0;
         toggle_cnt_r <= 5'd0;
         banner_y     <= START_Y;
         char_en      <= '0;
         visible      <= 1'b0;
         busy         <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               frame_cnt_r  <= 8'd0;
               toggle_cnt_r <= 5'd0;
               banner_y     <= START_Y;
               char_en      <= '0;
               if (trigger) begin
                  state_r <= REVEAL;
                  visible <= 1'b1;
                  busy    <= 1'b1;
               end else begin
                  state_r <= IDLE;
                  visible <= 1'b0;
                  busy    <= 1'b0;
               end
            end
            REVEAL: begin
               if (frame_tick) begin
                  if (frame_inc_s == REVEAL_LAST) begin
                     frame_cnt_r <= 8'd0;
                     char_en     <= char_next_s;
                     if (char_next_s[NCHARS-1]) begin
                        state_r <= SLIDE;
                     end
                  end else begin
                     frame_cnt_r <= frame_inc_s;
                  end
               end
            end
            SLIDE: begin
               if (frame_tick) begin
                  banner_y <= y_next_s;
                  if (y_next_s == TARGET_Y) begin
                     state_r      <= BLINK;
                     frame_cnt_r  <= 8'd0;
                     toggle_cnt_r <= 5'd0;
                  end
               end
            end
            BLINK: begin
               if (frame_tick) begin
                  if (frame_inc_s == BLINK_LAST) begin
                     frame_cnt_r  <= 8'd0;
                     visible      <= ~visible;
                     toggle_cnt_r <= toggle_inc_s;
                     if (toggle_inc_s == TOGGLE_LAST) begin
                        state_r  <= HOLD;
                        visible  <= 1'b1;
                        char_en  <= CHAR_ALL;
                        banner_y <= TARGET_Y;
                     end
                  end else begin
                     frame_cnt_r <= frame_inc_s;
                  end
               end
            end
            HOLD: begin
               visible  <= 1'b1;
               busy     <= 1'b1;
               char_en  <= CHAR_ALL;
               banner_y <= TARGET_Y;
            end
            default: begin
               state_r      <= IDLE;
               frame_cnt_r  <= 8'd0;
               toggle_cnt_r <= 5'd0;
               banner_y     <= START_Y;
               char_en      <= '0;
               visible      <= 1'b0;
               busy         <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_glyph_banner_ctrl.sv
// Directed bench for glyph_banner_ctrl: a vector table for the full default
// sequence plus hand sequences for reset, abort and the degenerate slide.
module tb_glyph_banner_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       frame_tick = 1'b0;
   logic       trigger = 1'b0;
   logic       ack = 1'b0;
   logic [9:0] banner_y, d_banner_y;
   logic [7:0] char_en, d_char_en;
   logic       visible, d_visible;
   logic       busy, d_busy;

   int n_vec = 0;
   int n_err = 0;

   glyph_banner_ctrl u_dut (
      .clk(clk), .reset(reset), .frame_tick(frame_tick), .trigger(trigger), .ack(ack),
      .banner_y(banner_y), .char_en(char_en), .visible(visible), .busy(busy)
   );

   glyph_banner_ctrl #(.START_Y(10'd100), .TARGET_Y(10'd100)) u_deg (
      .clk(clk), .reset(reset), .frame_tick(frame_tick), .trigger(trigger), .ack(ack),
      .banner_y(d_banner_y), .char_en(d_char_en), .visible(d_visible), .busy(d_busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       tg;
      logic       ak;
      logic       pt;
      int         ticks;
      logic [9:0] y;
      logic [7:0] ce;
      logic       v;
      logic       b;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic tg, logic ak, logic pt, int ticks,
                               logic [9:0] y, logic [7:0] ce, logic v, logic b);
      vec_t r;
      r.tg = tg; r.ak = ak; r.pt = pt; r.ticks = ticks;
      r.y = y; r.ce = ce; r.v = v; r.b = b;
      return r;
   endfunction

   // One clock with the given inputs, released #1 after the edge
   task automatic cyc(input logic ft, input logic tg, input logic ak);
      frame_tick = ft; trigger = tg; ack = ak;
      @(posedge clk); #1;
      frame_tick = 1'b0; trigger = 1'b0; ack = 1'b0;
   endtask

   task automatic tick_n(input int n);
      for (int i = 0; i < n; i++) begin
         cyc(1'b1, 1'b0, 1'b0);
         repeat (99) cyc(1'b0, 1'b0, 1'b0);
      end
   endtask

   task automatic check(input string name, input logic [9:0] ay, input logic [7:0] ace,
                        input logic av, input logic ab, input logic [9:0] ey,
                        input logic [7:0] ece, input logic ev, input logic eb);
      n_vec++;
      if (ay !== ey || ace !== ece || av !== ev || ab !== eb) begin
         n_err++;
         $display("FAIL %s: got banner_y=%0d char_en=%h visible=%b busy=%b, expected banner_y=%0d char_en=%h visible=%b busy=%b",
                  name, ay, ace, av, ab, ey, ece, ev, eb);
      end
   endtask

   initial begin
      // Full default sequence, ticks every 100 cycles; running tick count in comments
      vecs.push_back(mk(0, 0, 0,  0, 10'd0,   8'h00, 0, 0)); // reset state
      vecs.push_back(mk(1, 0, 0,  0, 10'd0,   8'h00, 1, 1)); // trigger
      vecs.push_back(mk(0, 0, 0,  3, 10'd0,   8'h00, 1, 1)); // 3
      vecs.push_back(mk(0, 0, 0,  1, 10'd0,   8'h01, 1, 1)); // 4
      vecs.push_back(mk(0, 0, 0,  4, 10'd0,   8'h03, 1, 1)); // 8
      vecs.push_back(mk(0, 0, 0,  4, 10'd0,   8'h07, 1, 1)); // 12
      vecs.push_back(mk(1, 0, 0,  0, 10'd0,   8'h07, 1, 1)); // retrigger ignored
      vecs.push_back(mk(0, 0, 0,  4, 10'd0,   8'h0F, 1, 1)); // 16
      vecs.push_back(mk(0, 0, 0, 16, 10'd0,   8'hFF, 1, 1)); // 32 -> SLIDE
      vecs.push_back(mk(0, 0, 0,  1, 10'd8,   8'hFF, 1, 1)); // 33
      vecs.push_back(mk(0, 0, 0, 26, 10'd216, 8'hFF, 1, 1)); // 59
      vecs.push_back(mk(0, 0, 0,  1, 10'd220, 8'hFF, 1, 1)); // 60 -> BLINK
      vecs.push_back(mk(0, 0, 0, 14, 10'd220, 8'hFF, 1, 1)); // 74
      vecs.push_back(mk(0, 0, 0,  1, 10'd220, 8'hFF, 0, 1)); // 75 first toggle off
      vecs.push_back(mk(0, 0, 0, 15, 10'd220, 8'hFF, 1, 1)); // 90
      vecs.push_back(mk(0, 0, 0, 59, 10'd220, 8'hFF, 0, 1)); // 149
      vecs.push_back(mk(0, 0, 0,  1, 10'd220, 8'hFF, 1, 1)); // 150 -> HOLD
      vecs.push_back(mk(0, 0, 0, 15, 10'd220, 8'hFF, 1, 1)); // HOLD ignores ticks
      vecs.push_back(mk(0, 1, 0,  0, 10'd0,   8'h00, 0, 0)); // ack -> IDLE
      vecs.push_back(mk(0, 1, 0,  2, 10'd0,   8'h00, 0, 0)); // ack in IDLE
      vecs.push_back(mk(1, 1, 1,  0, 10'd0,   8'h00, 1, 1)); // trigger+ack+tick
      vecs.push_back(mk(0, 0, 0,  3, 10'd0,   8'h00, 1, 1)); // tick was not counted
      vecs.push_back(mk(0, 0, 0,  1, 10'd0,   8'h01, 1, 1));
      vecs.push_back(mk(0, 1, 0,  0, 10'd0,   8'h00, 0, 0));

      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      repeat (10) cyc(1'b0, 1'b0, 1'b0);

      for (int i = 0; i < vecs.size(); i++) begin
         if (vecs[i].tg || vecs[i].ak || vecs[i].pt)
            cyc(vecs[i].pt, vecs[i].tg, vecs[i].ak);
         tick_n(vecs[i].ticks);
         check($sformatf("vec%0d", i), banner_y, char_en, visible, busy,
               vecs[i].y, vecs[i].ce, vecs[i].v, vecs[i].b);
      end

      // Asynchronous reset mid-SLIDE at banner_y = 96
      cyc(1'b0, 1'b1, 1'b0);
      tick_n(44);
      check("pre_reset_slide", banner_y, char_en, visible, busy, 10'd96, 8'hFF, 1'b1, 1'b1);
      #3 reset = 1'b1;
      #1;
      check("async_reset", banner_y, char_en, visible, busy, 10'd0, 8'h00, 1'b0, 1'b0);
      @(posedge clk); #1 reset = 1'b0;
      cyc(1'b1, 1'b0, 1'b0);
      check("after_reset", banner_y, char_en, visible, busy, 10'd0, 8'h00, 1'b0, 1'b0);

      // Abort during BLINK on the tick that would turn the banner back on
      cyc(1'b0, 1'b1, 1'b0);
      tick_n(89);
      check("blink_off", banner_y, char_en, visible, busy, 10'd220, 8'hFF, 1'b0, 1'b1);
      cyc(1'b1, 1'b0, 1'b1);
      check("abort", banner_y, char_en, visible, busy, 10'd0, 8'h00, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0);
      tick_n(4);
      check("restart", banner_y, char_en, visible, busy, 10'd0, 8'h01, 1'b1, 1'b1);
      cyc(1'b0, 1'b0, 1'b1);

      // Degenerate slide on the START_Y = TARGET_Y = 100 instance
      reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      check("deg_reset", d_banner_y, d_char_en, d_visible, d_busy, 10'd100, 8'h00, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0);
      tick_n(32);
      check("deg_revealed", d_banner_y, d_char_en, d_visible, d_busy, 10'd100, 8'hFF, 1'b1, 1'b1);
      tick_n(1);
      check("deg_slide", d_banner_y, d_char_en, d_visible, d_busy, 10'd100, 8'hFF, 1'b1, 1'b1);
      tick_n(14);
      check("deg_blink14", d_banner_y, d_char_en, d_visible, d_busy, 10'd100, 8'hFF, 1'b1, 1'b1);
      tick_n(1);
      check("deg_blink15", d_banner_y, d_char_en, d_visible, d_busy, 10'd100, 8'hFF, 1'b0, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/glyph_banner_ctrl.md
# glyph_banner_ctrl

Sequencer for the on-screen text banners, such as "GAME OVER". It drives a row of glyph renderers, each one a combinational hit test positioned by start_x/start_y. On a trigger it reveals the characters one per interval (typewriter style), slides the whole row down to its resting line, blinks it, and then holds it until acknowledged. It sits between the game-state logic and the glyph renderers, and advances once per video frame.

## Interface
- NCHARS, 8: number of glyph slots in the banner (1..16)
- REVEAL_FRAMES, 4: frames between successive character reveals (1..255)
- START_Y, 0: banner top row during reveal; 10-bit
- TARGET_Y, 220: resting top row after slide; must be >= START_Y; 10-bit
- SLIDE_STEP, 8: pixels moved per frame during slide (1..63)
- BLINK_FRAMES, 15: frames per blink half-period (1..255)
- BLINK_COUNT, 3: number of off/on blink pairs (1..15)
- clk  in  1  system clock; the only clock
- reset  in  1  asynchronous, active-high; forces all state to reset values
- frame_tick  in  1  single-cycle pulse once per frame (vsync-derived, synchronous to clk)
- trigger  in  1  start a banner sequence; level sampled each cycle
- ack  in  1  dismiss or abort the banner; level sampled each cycle
- banner_y  out  10  top row for every glyph renderer; renderer i uses start_x = BANNER_X + i*pitch, computed outside this block
- char_en  out  NCHARS  per-slot enable; bit 0 is the leftmost glyph; glyph i is gated by char_en[i] & visible
- visible  out  1  global banner visibility
- busy  out  1  high whenever state is not IDLE

## Operation
- All outputs are registered. Reset values: state IDLE, banner_y = START_Y, char_en = 0, visible = 0, busy = 0, frame counter = 0, toggle counter = 0.
- Frame-based counting advances only on cycles where frame_tick = 1.
- IDLE:
  - Outputs hold reset values.
  - trigger = 1 → REVEAL; visible = 1, busy = 1, char_en = 0, banner_y = START_Y, frame counter = 0.
  - A frame_tick in the same cycle as trigger is not counted.
- REVEAL:
  - Frame counter increments on each tick.
  - When it reaches REVEAL_FRAMES, it clears and the lowest clear bit of char_en is set.
  - The tick that sets bit NCHARS-1 also moves the state to SLIDE.
- SLIDE:
  - Each tick: banner_y = min(banner_y + SLIDE_STEP, TARGET_Y). Compute in 11 bits, then saturate.
  - The tick whose result equals TARGET_Y moves to BLINK, with frame counter and toggle counter cleared.
  - If START_Y == TARGET_Y, the first tick moves to BLINK and banner_y is unchanged.
- BLINK:
  - Frame counter counts ticks. At BLINK_FRAMES it clears, visible toggles, and the toggle counter increments.
  - The first toggle turns the banner off.
  - The tick producing toggle 2*BLINK_COUNT (visible back to 1) moves to HOLD.
- HOLD:
  - visible = 1, char_en all ones, banner_y = TARGET_Y.
  - Waits for ack.
- Dismiss and abort:
  - ack = 1 in any non-IDLE state → IDLE on the next edge, with all outputs at reset values.
  - ack has priority over frame_tick in the same cycle.
  - ack in IDLE has no effect. If trigger and ack are both high in IDLE, trigger wins.
- trigger is ignored while busy; no restart mid-sequence.
- Reset asserted mid-sequence returns the block to IDLE immediately (asynchronous). Deassertion takes effect at the next clk edge.

## Timing
- trigger sampled high at edge N → busy, visible, and the REVEAL state are visible after edge N.
- char_en[k] sets on the (k+1)*REVEAL_FRAMES-th tick after entry. The reveal phase lasts NCHARS*REVEAL_FRAMES ticks.
- The slide phase lasts ceil((TARGET_Y - START_Y)/SLIDE_STEP) ticks, minimum 1.
- The blink phase lasts 2*BLINK_COUNT*BLINK_FRAMES ticks.
- Each output change occurs one clk after the causing tick or ack is sampled.
- Counters are 8-bit (frame) and 5-bit (toggle); no wrap is reachable within the parameter ranges.

## Test plan
- Reset mid-SLIDE: assert reset with banner_y = 96 → all outputs read back IDLE values immediately, without waiting for an edge; busy = 0.
- Full sequence with defaults: trigger at cycle 10, then one tick every 100 cycles.
  - char_en = 0x01 after tick 4; char_en = 0xFF after tick 32, entering SLIDE.
  - banner_y = 216 after tick 59 and 220 after tick 60, entering BLINK.
  - visible = 0 after tick 75.
  - HOLD after tick 150 with visible = 1.
  - ack → IDLE one cycle later.
- Abort: ack during BLINK coincident with a tick → next cycle visible = 0, char_en = 0, banner_y = 0, busy = 0; the toggle is not applied.
- Retrigger ignored: pulse trigger during REVEAL at char_en = 0x07 → the sequence continues unchanged; char_en = 0x0F after 4 more ticks.
- Same-cycle trigger and tick in IDLE → the frame counter stays 0; the first reveal still needs 4 further ticks.
- Degenerate slide: START_Y = TARGET_Y = 100 → a single SLIDE tick with banner_y held at 100, then BLINK.
